// File: rtl/mlsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlsu_pkg
//  Purpose  : Shared types and constants for the MLSU sequential-load
//             transaction controller: request, AR channel, per-beat control
//             record, in-flight queue entry and splitter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package mlsu_pkg;

   // Geometry the default struct layouts are sized for.
   localparam int unsigned c_def_addr_w      = 64;
   localparam int unsigned c_def_bus_nsize   = 5;   // 128-bit bus -> 32 nibbles
   localparam int unsigned c_def_lbn_w       = c_def_bus_nsize + 1;

   // AXI 4 KiB page, in bytes and in nibbles.
   localparam int unsigned c_page_bytes      = 4096;
   localparam int unsigned c_page_nibbles    = 2 * c_page_bytes;

   localparam logic [1:0]  c_axi_burst_incr  = 2'b01;

   // Sequential load request, nibble granular.
   typedef struct packed {
      logic [c_def_addr_w:0] nbAddr;   // start nibble address
      logic [c_def_addr_w:0] lenNb;    // total nibbles
   } mlsu_req_t;

   typedef struct packed {
      logic [3:0]              id;
      logic [c_def_addr_w-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic                    lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
   } mlsu_axi_ar_t;

   // One record per R beat, consumed by the sequential load datapath.
   typedef struct packed {
      logic [c_def_addr_w:0]  addr;
      logic                   isHead;
      logic [7:0]             rmnBeat;
      logic [c_def_lbn_w-1:0] lbN;
      logic                   isFinalTxn;
   } mlsu_txn_ctrl_t;

   // One record per issued burst, held until all its beats are emitted.
   typedef struct packed {
      logic [c_def_addr_w:0]  addr;
      logic [7:0]             lenBeat;
      logic [c_def_lbn_w-1:0] lbN;
      logic                   isFinalTxn;
   } mlsu_txn_entry_t;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SPLIT = 1'b1
   } split_state_e;

endpackage
`default_nettype wire

// File: rtl/mlsu_txn_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mlsu_txn_fifo
//  Purpose  : Registered (no fall-through) FIFO for in-flight burst records.
//             Pointers are circular-queue style {flag, value}: the flag flips
//             on every wrap so full/empty are told apart without a counter.
//  Ports    : clk_i, rst_ni      - clock, async active-low reset
//             push_i, data_i     - write side (caller must not push when full)
//             pop_i,  data_o     - read side, data_o is the head entry
//             full_o, empty_o    - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module mlsu_txn_fifo #(
   parameter type         entry_t = logic,
   parameter int unsigned Depth   = 4
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   push_i,
   input  entry_t data_i,
   input  logic   pop_i,
   output entry_t data_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;

   typedef struct packed {
      logic               flag;
      logic [c_ptr_w-1:0] value;
   } queue_ptr_t;

   function automatic queue_ptr_t ptr_inc(input queue_ptr_t p);
      queue_ptr_t n;
      n = p;
      if (p.value == c_ptr_w'(Depth - 1)) begin
         n.value = '0;
         n.flag  = ~p.flag;
      end else begin
         n.value = p.value + c_ptr_w'(1);
      end
      return n;
   endfunction

   entry_t     r_mem [Depth];
   queue_ptr_t r_wr_ptr;
   queue_ptr_t r_rd_ptr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
   end

   // Payload storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[r_wr_ptr.value] <= data_i;
   end

   assign data_o  = r_mem[r_rd_ptr.value];
   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr.value == r_rd_ptr.value) && (r_wr_ptr.flag != r_rd_ptr.flag);

endmodule
`default_nettype wire

// File: rtl/mlsu_seq_load_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mlsu_seq_load_txn_ctrl
//  Purpose  : Splits one nibble-granular sequential load into AXI4 INCR read
//             bursts (never crossing 4 KiB, at most MaxBurstBeats beats) and
//             emits one control record per R beat, in AR order.
//  Ports    : clk_i, rst_ni                          - clock, async reset
//             req_valid_i/req_ready_o/req_i          - load request
//             axi_ar_valid_o/axi_ar_ready_i/axi_ar_o - AR channel
//             txn_ctrl_valid_o/_ready_i/txn_ctrl_o   - per-beat control
//             busy_o                                 - splitter or queue active
//  Revision : 1.0 - initial release
// ============================================================================
module mlsu_seq_load_txn_ctrl
   import mlsu_pkg::*;
#(
   parameter int unsigned AxiDataWidth  = 128,
   parameter int unsigned AxiAddrWidth  = 64,
   parameter int unsigned MaxBurstBeats = 16,
   parameter int unsigned NrOutstanding = 4,
   parameter type         req_t         = mlsu_req_t,
   parameter type         axi_ar_t      = mlsu_axi_ar_t,
   parameter type         txn_ctrl_t    = mlsu_txn_ctrl_t
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      req_valid_i,
   output logic      req_ready_o,
   input  req_t      req_i,
   output logic      axi_ar_valid_o,
   input  logic      axi_ar_ready_i,
   output axi_ar_t   axi_ar_o,
   output logic      txn_ctrl_valid_o,
   input  logic      txn_ctrl_ready_i,
   output txn_ctrl_t txn_ctrl_o,
   output logic      busy_o
);

   localparam int unsigned c_nb_w        = AxiAddrWidth + 1;
   localparam int unsigned c_bus_nibbles = AxiDataWidth / 4;
   localparam int unsigned c_bus_nsize   = $clog2(c_bus_nibbles);
   localparam int unsigned c_ax_size     = $clog2(AxiDataWidth / 8);
   localparam int unsigned c_lbn_w       = c_bus_nsize + 1;
   localparam int unsigned c_page_beats  = c_page_nibbles / c_bus_nibbles;

   localparam logic [AxiAddrWidth-1:0] c_beat_mask =
      {{(AxiAddrWidth - c_ax_size){1'b1}}, {c_ax_size{1'b0}}};

   // ------------------------------------------------------------------------
   // Splitter state
   // ------------------------------------------------------------------------
   split_state_e      r_state, w_state_nxt;
   logic [c_nb_w-1:0] r_cur,   w_cur_nxt;
   logic [c_nb_w-1:0] r_rmn,   w_rmn_nxt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   mlsu_txn_entry_t   w_push_entry;
   mlsu_txn_entry_t   w_head;
   logic [7:0]        r_beat_cnt;
   logic [7:0]        w_rmn_beat;

   // ------------------------------------------------------------------------
   // Burst sizing from the current position
   // ------------------------------------------------------------------------
   logic [c_nb_w-1:0]  w_off;
   logic [c_nb_w-1:0]  w_span;
   logic [c_nb_w-1:0]  w_need;
   logic [c_nb_w-1:0]  w_to_pg;
   logic [c_nb_w-1:0]  w_beats;
   logic [c_nb_w-1:0]  w_adv;
   logic               w_final;
   logic [c_lbn_w-1:0] w_lbn;

   assign w_off   = c_nb_w'(r_cur[c_bus_nsize-1:0]);
   assign w_span  = w_off + r_rmn;
   assign w_need  = (w_span + c_nb_w'(c_bus_nibbles - 1)) >> c_bus_nsize;
   assign w_to_pg = c_nb_w'(c_page_beats) - c_nb_w'(r_cur[12:c_bus_nsize]);

   always_comb begin
      w_beats = w_need;
      if (w_beats > c_nb_w'(MaxBurstBeats)) w_beats = c_nb_w'(MaxBurstBeats);
      if (w_beats > w_to_pg)                w_beats = w_to_pg;
   end

   assign w_final = (w_beats == w_need);

   // Only the first burst can start mid-beat; every later one is beat-aligned.
   assign w_adv = (w_beats << c_bus_nsize) - w_off;

   // Valid nibbles in the last beat: 1..busNibbles, hence one extra bit.
   assign w_lbn = w_final ? ({1'b0, c_bus_nsize'(w_span - c_nb_w'(1))} + c_lbn_w'(1))
                          : c_lbn_w'(c_bus_nibbles);

   // ------------------------------------------------------------------------
   // Splitter FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cur   <= '0;
         r_rmn   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_rmn   <= w_rmn_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_nxt      = r_cur;
      w_rmn_nxt      = r_rmn;
      req_ready_o    = 1'b0;
      axi_ar_valid_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            // Zero-length requests are swallowed without leaving idle.
            if (req_valid_i && (req_i.lenNb != '0)) begin
               w_cur_nxt   = req_i.nbAddr;
               w_rmn_nxt   = req_i.lenNb;
               w_state_nxt = S_SPLIT;
            end
         end
         S_SPLIT: begin
            axi_ar_valid_o = !w_full;
            if (!w_full && axi_ar_ready_i) begin
               if (w_final) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cur_nxt = r_cur + w_adv;
                  w_rmn_nxt = r_rmn - w_adv;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_push = (r_state == S_SPLIT) && !w_full && axi_ar_ready_i;

   always_comb begin
      axi_ar_o       = '0;
      axi_ar_o.addr  = r_cur[c_nb_w-1:1] & c_beat_mask;
      axi_ar_o.len   = 8'(w_beats - c_nb_w'(1));
      axi_ar_o.size  = 3'(c_ax_size);
      axi_ar_o.burst = c_axi_burst_incr;
   end

   always_comb begin
      w_push_entry            = '0;
      w_push_entry.addr       = r_cur;
      w_push_entry.lenBeat    = 8'(w_beats - c_nb_w'(1));
      w_push_entry.lbN        = w_lbn;
      w_push_entry.isFinalTxn = w_final;
   end

   // ------------------------------------------------------------------------
   // In-flight burst queue
   // ------------------------------------------------------------------------
   mlsu_txn_fifo #(
      .entry_t (mlsu_txn_entry_t),
      .Depth   (NrOutstanding)
   ) u_txn_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .data_i  (w_push_entry),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // ------------------------------------------------------------------------
   // Beat sequencer on the queue head
   // ------------------------------------------------------------------------
   assign w_rmn_beat = w_head.lenBeat - r_beat_cnt;
   assign w_pop      = txn_ctrl_valid_o && txn_ctrl_ready_i && (w_rmn_beat == 8'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_beat_cnt <= 8'd0;
      end else if (txn_ctrl_valid_o && txn_ctrl_ready_i) begin
         r_beat_cnt <= (w_rmn_beat == 8'd0) ? 8'd0 : r_beat_cnt + 8'd1;
      end
   end

   assign txn_ctrl_valid_o = !w_empty;

   always_comb begin
      txn_ctrl_o            = '0;
      txn_ctrl_o.addr       = w_head.addr;
      txn_ctrl_o.isHead     = (r_beat_cnt == 8'd0);
      txn_ctrl_o.rmnBeat    = w_rmn_beat;
      txn_ctrl_o.lbN        = w_head.lbN;
      txn_ctrl_o.isFinalTxn = w_head.isFinalTxn;
   end

   assign busy_o = (r_state != S_IDLE) || !w_empty;

   // ------------------------------------------------------------------------
   // Protocol invariants
   // ------------------------------------------------------------------------
   a_arlen_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      axi_ar_valid_o |-> ({24'd0, axi_ar_o.len} < 32'(MaxBurstBeats)));

   a_no_4k_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
      axi_ar_valid_o |-> (({20'd0, axi_ar_o.addr[11:0]} +
                           (({24'd0, axi_ar_o.len} + 32'd1) << c_ax_size)) <= 32'(c_page_bytes)));

   a_lbn_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      txn_ctrl_valid_o |-> ((txn_ctrl_o.lbN != '0) &&
                            ({{(32-c_lbn_w){1'b0}}, txn_ctrl_o.lbN} <= 32'(c_bus_nibbles))));

endmodule
`default_nettype wire
